nrs_re_mapper: RTL and testbench

NRS_RE_MAPPER -- requirements
Module: nrs_re_mapper

---
 rtl/nrs_re_mapper_if.sv | 23 ++
 rtl/nrs_re_mapper.sv | 172 +++++++++++++++++
 tb/tb_nrs_re_mapper.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/nrs_re_mapper_if.sv
// Resource-element stream from the NRS mapper to the grid writer.
// Valid/ready handshake; the payload is held while stalled.
interface nrs_re_if #(
    parameter int WIDTH_REG = 16
);
    logic                 re_valid;
    logic                 re_ready;
    logic [3:0]           re_symbol;
    logic [3:0]           re_subcarrier;
    logic                 re_port;
    logic [WIDTH_REG-1:0] re_real;
    logic [WIDTH_REG-1:0] re_imag;

    modport master (
        output re_valid, re_symbol, re_subcarrier, re_port, re_real, re_imag,
        input  re_ready
    );

    modport slave (
        input  re_valid, re_symbol, re_subcarrier, re_port, re_real, re_imag,
        output re_ready
    );
endinterface

// File: rtl/nrs_re_mapper.sv
// Copies one subframe of NRS words out of the generator store and streams them
// as resource elements (symbol, subcarrier, port, value) to the grid writer.
module nrs_re_mapper #(
    parameter int WIDTH_REG = 16,
    parameter int LINES     = 4,
    parameter int WIDTH_B   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 nrs_ready,
    input  logic [WIDTH_B-1:0]   N_cell_ID,
    input  logic                 two_ports,
    output logic [LINES-1:0]     rd_addr_1r,
    output logic [LINES-1:0]     rd_addr_1i,
    output logic [LINES-1:0]     rd_addr_2r,
    output logic [LINES-1:0]     rd_addr_2i,
    input  logic [WIDTH_REG-1:0] nrs_1r,
    input  logic [WIDTH_REG-1:0] nrs_1i,
    input  logic [WIDTH_REG-1:0] nrs_2r,
    input  logic [WIDTH_REG-1:0] nrs_2i,
    nrs_re_if.master             re_bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, EMIT} state_e;

    state_e               state_q, state_d;
    logic [1:0]           s_q;
    logic                 two_ports_q;
    logic [2:0]           vshift_q;
    logic [LINES-1:0]     rd_addr_q [4];
    logic                 cap_en_q;
    logic [1:0]           cap_s_q;
    logic [WIDTH_REG-1:0] buf_q [16];
    logic [4:0]           idx_q;
    logic                 valid_q, port_q, done_q, overrun_q;
    logic [3:0]           symbol_q, sc_q;
    logic [WIDTH_REG-1:0] real_q, imag_q;

    // Restoring reduction by 6*2^k: constant compares/subtracts, no divider.
    function automatic logic [2:0] mod6(input logic [WIDTH_B-1:0] x);
        logic [WIDTH_B-1:0] r;
        logic [WIDTH_B-1:0] sixk;
        r = x;
        for (int k = WIDTH_B - 3; k >= 0; k--) begin
            sixk = WIDTH_B'(6) << k;
            if (r >= sixk) r = r - sixk;
        end
        return r[2:0];
    endfunction

    // Emission index: idx[3:2] = symbol slot s, idx[1] = port, idx[0] = pilot m.
    logic [1:0] e_s;
    logic       e_port, e_m, load, last_xfer;
    logic [3:0] e_sum, e_rem, e_sc, e_sym;
    logic [4:0] idx_nxt;

    always_comb begin
        e_s     = idx_q[3:2];
        e_port  = idx_q[1];
        e_m     = idx_q[0];
        e_sum   = ((e_port == e_s[0]) ? 4'd0 : 4'd3) + {1'b0, vshift_q};
        e_rem   = (e_sum >= 4'd6) ? e_sum - 4'd6 : e_sum;
        e_sc    = e_m ? e_rem + 4'd6 : e_rem;
        unique case (e_s)
            2'd0:    e_sym = 4'd5;
            2'd1:    e_sym = 4'd6;
            2'd2:    e_sym = 4'd12;
            default: e_sym = 4'd13;
        endcase
        idx_nxt   = idx_q + ((two_ports_q || !idx_q[0]) ? 5'd1 : 5'd3);
        load      = (state_q == EMIT) && !idx_q[4] && (!valid_q || re_bus.re_ready);
        last_xfer = (state_q == EMIT) && idx_q[4] && valid_q && re_bus.re_ready;
    end

    // NOTE: state_d gets its default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (nrs_ready) state_d = READ;
            READ:    if (s_q == 2'd3) state_d = DRAIN;
            DRAIN:   state_d = EMIT;
            default: if (last_xfer) state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            two_ports_q <= 1'b0;
            vshift_q    <= '0;
            for (int i = 0; i < 4; i++) rd_addr_q[i] <= '0;
            cap_en_q    <= 1'b0;
            cap_s_q     <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            symbol_q    <= '0;
            sc_q        <= '0;
            port_q      <= 1'b0;
            real_q      <= '0;
            imag_q      <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= 1'b0;
            cap_en_q <= (state_q == READ);
            cap_s_q  <= s_q;
            if (nrs_ready && state_q != IDLE) overrun_q <= 1'b1;
            unique case (state_q)
                IDLE: if (nrs_ready) begin
                    two_ports_q <= two_ports;
                    vshift_q    <= mod6(N_cell_ID);
                    s_q         <= 2'd0;
                    idx_q       <= '0;
                    for (int i = 0; i < 4; i++) rd_addr_q[i] <= LINES'({2'd0, 2'(i)});
                end
                READ: begin
                    s_q <= s_q + 2'd1;
                    for (int i = 0; i < 4; i++)
                        rd_addr_q[i] <= (s_q == 2'd3) ? '0 : LINES'({s_q + 2'd1, 2'(i)});
                end
                DRAIN: ;
                default: begin
                    if (load) begin
                        valid_q  <= 1'b1;
                        symbol_q <= e_sym;
                        sc_q     <= e_sc;
                        port_q   <= e_port;
                        real_q   <= buf_q[{e_s, e_m, 1'b0}];
                        imag_q   <= buf_q[{e_s, e_m, 1'b1}];
                        idx_q    <= idx_nxt;
                    end else if (valid_q && re_bus.re_ready) begin
                        valid_q <= 1'b0;
                    end
                    if (last_xfer) done_q <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the buffer has no reset; every word is rewritten before EMIT reads it.
    always_ff @(posedge clk) begin
        if (cap_en_q) begin
            buf_q[{cap_s_q, 2'd0}] <= nrs_1r;
            buf_q[{cap_s_q, 2'd1}] <= nrs_1i;
            buf_q[{cap_s_q, 2'd2}] <= nrs_2r;
            buf_q[{cap_s_q, 2'd3}] <= nrs_2i;
        end
    end

    assign rd_addr_1r = rd_addr_q[0];
    assign rd_addr_1i = rd_addr_q[1];
    assign rd_addr_2r = rd_addr_q[2];
    assign rd_addr_2i = rd_addr_q[3];

    assign re_bus.re_valid      = valid_q;
    assign re_bus.re_symbol     = symbol_q;
    assign re_bus.re_subcarrier = sc_q;
    assign re_bus.re_port       = port_q;
    assign re_bus.re_real       = real_q;
    assign re_bus.re_imag       = imag_q;

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_nrs_re_mapper.sv
// Self-checking bench: generator store model, RE reference model built from the
// mapping rules, table-driven and randomized subframes plus reset/overrun sequences.
module tb_nrs_re_mapper;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        nrs_ready = 1'b0;
    logic [8:0]  N_cell_ID = '0;
    logic        two_ports = 1'b0;
    logic [3:0]  rd_addr_1r, rd_addr_1i, rd_addr_2r, rd_addr_2i;
    logic [15:0] nrs_1r, nrs_1i, nrs_2r, nrs_2i;
    logic        busy, done, overrun;

    nrs_re_if #(.WIDTH_REG(16)) re_bus ();

    nrs_re_mapper #(.WIDTH_REG(16), .LINES(4), .WIDTH_B(9)) dut (
        .clk(clk), .rst(rst), .nrs_ready(nrs_ready), .N_cell_ID(N_cell_ID),
        .two_ports(two_ports),
        .rd_addr_1r(rd_addr_1r), .rd_addr_1i(rd_addr_1i),
        .rd_addr_2r(rd_addr_2r), .rd_addr_2i(rd_addr_2i),
        .nrs_1r(nrs_1r), .nrs_1i(nrs_1i), .nrs_2r(nrs_2r), .nrs_2i(nrs_2i),
        .re_bus(re_bus), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Generator store: read data valid one cycle after the address.
    logic [15:0] gen_mem [16];
    always @(posedge clk) begin
        nrs_1r <= gen_mem[rd_addr_1r];
        nrs_1i <= gen_mem[rd_addr_1i];
        nrs_2r <= gen_mem[rd_addr_2r];
        nrs_2i <= gen_mem[rd_addr_2i];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  sym;
        logic [3:0]  sc;
        logic        port;
        logic [15:0] re;
        logic [15:0] im;
    } re_t;

    re_t        exp_q[$];
    int         n_xfer = 0;
    logic [3:0] first_sc = '0;
    re_t        held;
    bit         stalled = 1'b0;

    // Reference model straight from the mapping rules.
    task automatic build_expected(input int cid, input bit tp);
        int sym_tab [4] = '{5, 6, 12, 13};
        int vs = cid % 6;
        exp_q.delete();
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < (tp ? 2 : 1); p++)
                for (int m = 0; m < 2; m++) begin
                    re_t e;
                    int  v = (p == s % 2) ? 0 : 3;
                    e.sym  = 4'(sym_tab[s]);
                    e.sc   = 4'(6 * m + (v + vs) % 6);
                    e.port = 1'(p);
                    e.re   = gen_mem[4 * s + 2 * m];
                    e.im   = gen_mem[4 * s + 2 * m + 1];
                    exp_q.push_back(e);
                end
    endtask

    // Transfer monitor and stall-stability checker, sampled on the falling edge.
    always @(negedge clk) begin
        re_t a;
        a = re_t'({re_bus.re_symbol, re_bus.re_subcarrier, re_bus.re_port,
                   re_bus.re_real, re_bus.re_imag});
        if (stalled) check("hold_stable", {re_bus.re_valid, a}, {1'b1, held});
        if (re_bus.re_valid && re_bus.re_ready) begin
            check("re_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                if (n_xfer == 0) first_sc = a.sc;
                check("re_value", a, exp_q.pop_front());
            end
            n_xfer++;
        end
        stalled = re_bus.re_valid && !re_bus.re_ready;
        held    = a;
    end

    task automatic check_reset_state();
        check("rst_re_valid", re_bus.re_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_addr", {rd_addr_1r, rd_addr_1i, rd_addr_2r, rd_addr_2i}, 0);
        check("rst_re_data", {re_bus.re_symbol, re_bus.re_subcarrier, re_bus.re_port,
                              re_bus.re_real, re_bus.re_imag}, 0);
    endtask

    // Loads fresh store contents and pulses nrs_ready; returns just after edge T0.
    task automatic start_subframe(input int cid, input bit tp, input bit b2b);
        if (!b2b) @(negedge clk);
        for (int i = 0; i < 16; i++) gen_mem[i] = 16'($urandom);
        build_expected(cid, tp);
        n_xfer    = 0;
        N_cell_ID = 9'(cid);
        two_ports = tp;
        nrs_ready = 1'b1;
        @(posedge clk);
        #1 nrs_ready = 1'b0;
    endtask

    // Runs until done; rewrites the store once DRAIN is over; optional nrs_ready inject.
    task automatic run_to_done(input bit rmode, input int inject_t, input int exp_n,
                               input int exp_done_t);
        int t = 0;
        int first_v = -1;
        bit done_seen = 1'b0;
        re_bus.re_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        while (1) begin
            @(negedge clk);
            if (re_bus.re_valid && first_v < 0) first_v = t;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (t >= 400) break;
            @(posedge clk);
            #1 t++;
            re_bus.re_ready = rmode ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            nrs_ready = (t == inject_t);
            if (t == 5) for (int i = 0; i < 16; i++) gen_mem[i] = 16'($urandom);
        end
        check("done_seen", done_seen, 1);
        check("first_valid_cycle", 64'(first_v), 64'(6));
        if (!rmode) check("done_cycle", 64'(t), 64'(exp_done_t));
        check("re_count", 64'(n_xfer), 64'(exp_n));
        check("queue_empty", 64'(exp_q.size()), 0);
        check("busy_low_in_done_cycle", busy, 0);
    endtask

    typedef struct {
        int cid;
        bit tp;
        int exp_n;
        int exp_done_t;
        int exp_k0;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   quiet;
        vecs = '{'{0,   1'b1, 16, 22, 0},
                 '{7,   1'b0, 8,  14, 1},
                 '{503, 1'b1, 16, 22, 5},
                 '{9,   1'b0, 8,  14, 3},
                 '{260, 1'b1, 16, 22, 2}};

        for (int i = 0; i < 16; i++) gen_mem[i] = '0;
        re_bus.re_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        // Directed subframes (V1, V2) with re_ready held high.
        for (int i = 0; i < 5; i++) begin
            start_subframe(vecs[i].cid, vecs[i].tp, 1'b0);
            run_to_done(1'b0, -1, vecs[i].exp_n, vecs[i].exp_done_t);
            check("first_subcarrier", first_sc, 64'(vecs[i].exp_k0));
        end
        check("overrun_quiet", overrun, 0);

        // V3: pseudo-random back-pressure.
        start_subframe(0, 1'b1, 1'b0);
        run_to_done(1'b1, -1, 16, 22);

        // V4: nrs_ready during EMIT, then back-to-back start in the done cycle.
        start_subframe(123, 1'b1, 1'b0);
        run_to_done(1'b1, 12, 16, 22);
        check("overrun_set", overrun, 1);
        start_subframe(44, 1'b0, 1'b1);
        run_to_done(1'b0, -1, 8, 14);
        check("overrun_sticky", overrun, 1);

        // V5: reset at the third transfer aborts the subframe.
        re_bus.re_ready = 1'b1;
        start_subframe(5, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        check("xfers_before_reset", 64'(n_xfer), 64'(3));
        exp_q.delete();
        rst   = 1'b1;
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            quiet = quiet | int'(done) | int'(busy) | int'(re_bus.re_valid);
        end
        check("no_activity_after_abort", 64'(quiet), 0);
        start_subframe(100, 1'b1, 1'b0);
        run_to_done(1'b0, -1, 16, 22);

        // Randomized subframes against the reference model.
        for (int r = 0; r < 6; r++) begin
            int cid = int'($urandom_range(0, 503));
            bit tp  = 1'($urandom_range(0, 1));
            bit rm  = 1'($urandom_range(0, 1));
            start_subframe(cid, tp, 1'b0);
            run_to_done(rm, -1, tp ? 16 : 8, tp ? 22 : 14);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
